// File: rtl/mst_arb_pkg.sv
// mst_arb_pkg: shared encodings for the master FIFO write-port arbiter
package mst_arb_pkg;
  localparam int MST_W = 18;
  localparam logic [1:0] MST_EOP_TAG = 2'b01;
  localparam logic [3:0] MST_CMD_WR = 4'b1010;
  localparam logic [3:0] MST_CMD_RD = 4'b0000;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT, ARB_GAP} arb_state_t;
  function automatic logic is_eop(input logic [MST_W-1:0] w);
    return w[17:16] == MST_EOP_TAG;
  endfunction
endpackage

// File: rtl/mst_arb_pick.sv
// mst_arb_pick: combinational round-robin / fixed-priority winner select
module mst_arb_pick #(
  parameter bit PRIO_REQ0 = 1'b0
) (
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic vld,
  output logic sel
);
  always_comb begin
    vld = req0 | req1;
    sel = (req0 & req1) ? (PRIO_REQ0 ? 1'b0 : ~rr_last) : req1;
  end
endmodule

// File: rtl/mst_arbiter.sv
// mst_arbiter: packet-atomic arbitration of two requesters onto the master FIFO write port
// Optional watchdog on a stalled owner: define MST_ARB_WATCHDOG_EN.
module mst_arbiter
  import mst_arb_pkg::*;
#(
  parameter bit PRIO_REQ0 = 1'b0,
  parameter int TIMEOUT   = 1023
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             req0_req,
  output logic             req0_gnt,
  input  logic [MST_W-1:0] req0_din,
  input  logic             req0_wr_en,
  output logic             req0_full,
  input  logic             req1_req,
  output logic             req1_gnt,
  input  logic [MST_W-1:0] req1_din,
  input  logic             req1_wr_en,
  output logic             req1_full,
  output logic [MST_W-1:0] mst_din,
  output logic             mst_wr_en,
  input  logic             mst_full,
  output logic [15:0]      pkt_cnt0,
  output logic [15:0]      pkt_cnt1,
  output logic             err_drop,
  output logic             err_tmo,
  input  logic             err_clr
);
  arb_state_t state, state_nx;
  logic owner, rr_last, pick_vld, pick_sel, acc, eop, tmo, drop;
  logic [MST_W-1:0] own_din;

  mst_arb_pick #(.PRIO_REQ0(PRIO_REQ0)) u_pick (
    .req0(req0_req),
    .req1(req1_req),
    .rr_last(rr_last),
    .vld(pick_vld),
    .sel(pick_sel)
  );

  always_comb begin
    req0_gnt  = (state == ARB_GNT) & ~owner;
    req1_gnt  = (state == ARB_GNT) & owner;
    req0_full = mst_full | ~req0_gnt;
    req1_full = mst_full | ~req1_gnt;
    own_din   = owner ? req1_din : req0_din;
    acc       = ((req0_gnt & req0_wr_en) | (req1_gnt & req1_wr_en)) & ~mst_full;
    eop       = acc & is_eop(own_din);
    drop      = (req0_wr_en & ~req0_gnt) | (req1_wr_en & ~req1_gnt) | ((req0_wr_en | req1_wr_en) & mst_full);
    state_nx  = (state == ARB_IDLE) ? (pick_vld ? ARB_GNT : ARB_IDLE) :
                (state == ARB_GNT)  ? ((eop | tmo) ? ARB_GAP : ARB_GNT) : ARB_IDLE;
  end

`ifdef MST_ARB_WATCHDOG_EN
  localparam int WDW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  logic [WDW-1:0] wd_cnt;
  // counts consecutive owned cycles without an accepted word
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) wd_cnt <= '0;
    else wd_cnt <= (state == ARB_GNT && !acc) ? wd_cnt + 1'b1 : '0;
  assign tmo = (state == ARB_GNT) & ~acc & (wd_cnt == WDW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= ARB_IDLE;
    else state <= state_nx;

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      owner     <= 1'b0;
      rr_last   <= 1'b1;
      pkt_cnt0  <= '0;
      pkt_cnt1  <= '0;
      mst_din   <= '0;
      mst_wr_en <= 1'b0;
      err_drop  <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      owner     <= (state == ARB_IDLE && pick_vld) ? pick_sel : owner;
      rr_last   <= eop ? owner : rr_last;
      pkt_cnt0  <= pkt_cnt0 + 16'(eop & ~owner);
      pkt_cnt1  <= pkt_cnt1 + 16'(eop & owner);
      mst_din   <= acc ? own_din : mst_din;
      mst_wr_en <= acc;
      err_drop  <= drop | (err_drop & ~err_clr);
      err_tmo   <= tmo | (err_tmo & ~err_clr);
    end
endmodule
